// File: rtl/medidor_frecuencia_if.sv
// Signal bundle for medidor_frecuencia: slow clock and enable in, measurement results out.
interface medidor_frecuencia_if #(
  parameter int WIDTH = 16
);
  logic             sclk_in;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [WIDTH-1:0] high_time;

  modport master (
    output sclk_in, enable,
    input  period, period_valid, locked, timeout, high_time
  );

  modport slave (
    input  sclk_in, enable,
    output period, period_valid, locked, timeout, high_time
  );
endinterface

// File: rtl/medidor_frecuencia.sv
// Measures the period of slow clock sclk_in in clk cycles, with lock and stall detection.
// Define MEDIDOR_DUTY_EN to also report how long sclk_in was high in each measured period.
module medidor_frecuencia #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  medidor_frecuencia_if.slave mf
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TMO_VAL = WIDTH'(TIMEOUT);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       wait_q, wait_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic                   have_prev_q, have_prev_d;

  logic sync_s, rise, tmo_hit, meas_start, meas_close, meas_run;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign rise       = sync_s & ~prev_q;
  assign tmo_hit    = (sat_inc(wait_q) == TMO_VAL);
  assign meas_start = mf.enable && ((state_q == S_ARM) || (state_q == S_MEAS)) && rise;
  assign meas_close = meas_start && (state_q == S_MEAS);
  assign meas_run   = mf.enable && (state_q == S_MEAS) && !rise && !tmo_hit;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], mf.sclk_in};
    prev_d      = sync_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    period_d    = period_q;
    pv_d        = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;
    if (!mf.enable) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      wait_d      = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        S_ARM, S_MEAS: begin
          if (meas_start) begin
            state_d   = S_MEAS;
            cnt_d     = CNT_ONE;
            wait_d    = CNT_ONE;
            timeout_d = 1'b0;
            // locked only compares against a period measured since the last (re)arm
            if (meas_close) begin
              period_d    = cnt_q;
              pv_d        = 1'b1;
              locked_d    = have_prev_q && (cnt_q == period_q);
              have_prev_d = 1'b1;
            end
          end else if (tmo_hit) begin
            state_d     = S_ARM;
            cnt_d       = CNT_ONE;
            wait_d      = '0;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
          end else begin
            wait_d = sat_inc(wait_q);
            if (meas_run) cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = S_ARM;
          cnt_d   = CNT_ONE;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign mf.period       = period_q;
  assign mf.period_valid = pv_q;
  assign mf.locked       = locked_q;
  assign mf.timeout      = timeout_q;

`ifdef MEDIDOR_DUTY_EN
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_q, high_d;

  always_comb begin
    hcnt_d = '0;
    high_d = high_q;
    if (meas_close) high_d = hcnt_q;
    // the rise cycle itself has sclk high and opens the new period
    if (meas_start)               hcnt_d = CNT_ONE;
    else if (meas_run && sync_s)  hcnt_d = sat_inc(hcnt_q);
    else if (meas_run)            hcnt_d = hcnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign mf.high_time = high_q;
`else
  assign mf.high_time = '0;
`endif
endmodule

// File: tb/tb_medidor_frecuencia.sv
// Self-checking bench for medidor_frecuencia: table-driven ratios, directed corner sequences
// and randomized waveforms checked every cycle against an edge-timestamp reference model.
module tb_medidor_frecuencia;
  localparam int WIDTH = 16;
  localparam int TMO   = 100;
  localparam int SYNC  = 2;
  localparam int MAXC  = 16384;

  logic clk = 1'b0;
  logic reset = 1'b1;

  medidor_frecuencia_if #(.WIDTH(WIDTH)) bus_if ();

  medidor_frecuencia #(
    .WIDTH(WIDTH),
    .TIMEOUT(TMO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mf(bus_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // sclk_in as driven in each cycle, and the first cycle after the last reset
  bit hist [MAXC];
  int cyc  = 0;
  int base = 0;

  // reference model: timestamps of edges rather than any state machine
  bit m_on, m_meas, have_prev;
  int last_rise, ref_t;
  int e_period, e_high;
  bit e_pv, e_locked, e_tmo;

  int t_pv, t_lk, t_to, t_tc, pv_count;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
    bit exp_locked;
  } row_t;

  function automatic bit hs(input int k);
    if (k < base || k < 0 || k >= MAXC) return 1'b0;
    return hist[k];
  endfunction

  function automatic bit sync_at(input int m);
    return hs(m - SYNC);
  endfunction

  function automatic bit rise_at(input int m);
    return hs(m - SYNC) && !hs(m - SYNC - 1);
  endfunction

  task automatic model_clear();
    m_on = 0; m_meas = 0; have_prev = 0;
    last_rise = 0; ref_t = 0;
    e_period = 0; e_high = 0; e_pv = 0; e_locked = 0; e_tmo = 0;
  endtask

  // predicts the outputs visible in cycle m+1 from inputs of cycle m
  task automatic model_cycle(input int m, input bit en_v);
    e_pv = 1'b0;
    if (!en_v) begin
      m_on = 0; m_meas = 0; have_prev = 0; e_locked = 0; e_tmo = 0;
    end else if (!m_on) begin
      m_on = 1; m_meas = 0; ref_t = m + 1;
    end else if (rise_at(m)) begin
      if (m_meas) begin
        int p;
        p = m - last_rise;
        e_pv = 1'b1;
        e_locked = have_prev && (p == e_period);
        e_period = p;
        have_prev = 1'b1;
`ifdef MEDIDOR_DUTY_EN
        e_high = 0;
        for (int k = last_rise; k < m; k++) if (sync_at(k)) e_high++;
`endif
      end
      m_meas = 1; last_rise = m; ref_t = m; e_tmo = 0;
    end else if (m + 1 - ref_t == TMO) begin
      e_tmo = 1; e_locked = 0; m_meas = 0; have_prev = 0; ref_t = m + 1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    vectors++;
    if (int'(bus_if.period) != e_period || bus_if.period_valid != e_pv ||
        bus_if.locked != e_locked || bus_if.timeout != e_tmo || int'(bus_if.high_time) != e_high) begin
      miscompares++;
      $display("FAIL cycle%0d: got period=%0d pv=%0b locked=%0b timeout=%0b high=%0d, expected period=%0d pv=%0b locked=%0b timeout=%0b high=%0d",
               cyc, bus_if.period, bus_if.period_valid, bus_if.locked, bus_if.timeout, bus_if.high_time,
               e_period, e_pv, e_locked, e_tmo, e_high);
    end
  endtask

  task automatic clr_trk();
    t_pv = -1; t_lk = -1; t_to = -1; t_tc = -1; pv_count = 0;
  endtask

  task automatic step(input bit en_v, input bit s_v);
    bus_if.enable  = en_v;
    bus_if.sclk_in = s_v;
    if (cyc < MAXC) hist[cyc] = s_v;
    model_cycle(cyc, en_v);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (bus_if.period_valid) pv_count++;
    if (bus_if.period_valid && t_pv < 0) t_pv = cyc;
    if (bus_if.locked && t_lk < 0) t_lk = cyc;
    if (bus_if.timeout && t_to < 0) t_to = cyc;
    if (!bus_if.timeout && t_tc < 0) t_tc = cyc;
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b1, 1'b0);
    end
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic sync_reset();
    bus_if.enable  = 1'b0;
    bus_if.sclk_in = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    base = cyc;
    model_clear();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(bus_if.period), 0);
    chk({tag, "_pv"}, int'(bus_if.period_valid), 0);
    chk({tag, "_locked"}, int'(bus_if.locked), 0);
    chk({tag, "_timeout"}, int'(bus_if.timeout), 0);
    chk({tag, "_high"}, int'(bus_if.high_time), 0);
  endtask

  // toggling every 2 clk: valid after 2nd edge, lock after 3rd (edge latency SYNC+1)
  task automatic basic_ratio(input string tag);
    int r1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    clr_trk();
    r1 = cyc;
    run_wave(2, 2, 5);
    chk({tag, "_first_pv"}, t_pv - r1, 4 + SYNC + 1);
    chk({tag, "_first_lock"}, t_lk - r1, 8 + SYNC + 1);
    chk({tag, "_period"}, int'(bus_if.period), 4);
    chk({tag, "_no_timeout"}, t_to, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    row_t rows [4];
    int   r, exp_h, t_start;
    rows[0] = '{hi: 2, lo: 2, n: 4, exp_period: 4,  exp_high: 2, exp_locked: 1'b1};
    rows[1] = '{hi: 3, lo: 7, n: 4, exp_period: 10, exp_high: 3, exp_locked: 1'b1};
    rows[2] = '{hi: 1, lo: 1, n: 4, exp_period: 2,  exp_high: 1, exp_locked: 1'b1};
    rows[3] = '{hi: 5, lo: 1, n: 4, exp_period: 6,  exp_high: 5, exp_locked: 1'b1};

    bus_if.enable  = 1'b0;
    bus_if.sclk_in = 1'b0;
    model_clear();
    clr_trk();

    sync_reset();
    chk_zero("reset");

    for (int i = 0; i < 4; i++) begin
      sync_reset();
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
      run_wave(rows[i].hi, rows[i].lo, rows[i].n);
      idle_low(SYNC + 2);
`ifdef MEDIDOR_DUTY_EN
      exp_h = rows[i].exp_high;
`else
      exp_h = 0;
`endif
      chk("tbl_period", int'(bus_if.period), rows[i].exp_period);
      chk("tbl_locked", int'(bus_if.locked), int'(rows[i].exp_locked));
      chk("tbl_high", int'(bus_if.high_time), exp_h);
      chk("tbl_timeout", int'(bus_if.timeout), 0);
    end

    sync_reset();
    basic_ratio("basic");

    // stalled clock after the period-4 run; the 5th edge was driven at r1+16
    r = cyc - 4;
    clr_trk();
    for (int i = 0; i < 300 && t_to < 0; i++) step(1'b1, 1'b0);
    chk("stall_latency", t_to - r, TMO + SYNC);
    chk("stall_locked", int'(bus_if.locked), 0);
    chk("stall_no_pv", pv_count, 0);

    clr_trk();
    r = cyc;
    run_wave(2, 2, 3);
    chk("restart_timeout_clear", t_tc - r, SYNC + 1);
    chk("restart_first_pv", t_pv - r, 4 + SYNC + 1);
    chk("restart_period", int'(bus_if.period), 4);

    clr_trk();
    run_wave(3, 3, 2);
    chk("ratio_first6_period", int'(bus_if.period), 6);
    chk("ratio_first6_locked", int'(bus_if.locked), 0);
    chk("ratio_pulses", pv_count, 2);
    run_wave(3, 3, 1);
    chk("ratio_second6_locked", int'(bus_if.locked), 1);
    chk("ratio_second6_period", int'(bus_if.period), 6);

    run_wave(2, 2, 3);
    clr_trk();
    for (int i = 0; i < 20; i++) step(1'b0, (i < 16) ? 1'(((i / 2) % 2)) : 1'b0);
    chk("disable_period_hold", int'(bus_if.period), 4);
    chk("disable_locked", int'(bus_if.locked), 0);
    chk("disable_no_pv", pv_count, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    clr_trk();
    r = cyc;
    run_wave(2, 2, 4);
    chk("reenable_first_pv", t_pv - r, 4 + SYNC + 1);
    chk("reenable_period", int'(bus_if.period), 4);
    step(1'b1, 1'b1);
    chk("pre_reset_locked", int'(bus_if.locked), 1);

    // asynchronous reset mid-cycle: outputs must clear before any clk edge
    #2;
    reset = 1'b1;
    #1;
    chk_zero("areset");
    bus_if.enable  = 1'b0;
    bus_if.sclk_in = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    base = cyc;
    model_clear();
    basic_ratio("after_areset");

    t_start = cyc;
    while (cyc < t_start + 3000) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        int len;
        len = $urandom_range(1, 30);
        for (int i = 0; i < len; i++) step(1'b0, 1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        int len;
        bit lvl;
        len = $urandom_range(TMO, TMO + 60);
        lvl = 1'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) step(1'b1, lvl);
      end else begin
        run_wave($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
